pattern_cfg_apb: RTL

PATTERN_CFG_APB -- requirements
Module: pattern_cfg_apb

---
 rtl/pattern_cfg_apb_if.sv | 27 ++
 rtl/pattern_cfg_apb.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/pattern_cfg_apb_if.sv
// APB-style register bus between a master and the pattern_cfg_apb slave.
//   psel/penable/pwrite  : transfer control (setup phase, then access phase)
//   paddr[2:0]           : register address
//   pwdata[7:0]          : write data
//   prdata[7:0]          : read data, valid during a read access phase
//   pready               : transfer complete (no wait states)
//   pslverr              : transfer error, valid during the access phase
interface pattern_cfg_apb_if;
  logic       psel;
  logic       penable;
  logic       pwrite;
  logic [2:0] paddr;
  logic [7:0] pwdata;
  logic [7:0] prdata;
  logic       pready;
  logic       pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/pattern_cfg_apb.sv
// Register front end for a serial pattern detector.
// Holds the detector pattern, serializes bytes written to TXDATA (MSB first,
// with a one-deep holding register so consecutive bytes stream without a
// gap), and counts detect pulses returned from the detector.
// Ports:
//   clk       : clock, all state changes on the rising edge
//   rst       : asynchronous active-low reset
//   bus       : APB slave (psel, penable, pwrite, paddr, pwdata, prdata,
//               pready, pslverr)
//   pat_out   : programmed 5-bit pattern to the detector
//   ser_out   : serial data bit to the detector
//   ser_valid : ser_out carries a live bit this cycle
//   det_in    : detect pulse from the detector
// Register map: 0 CTRL (en, clr_cnt), 1 PATTERN, 2 TXDATA (WO),
//               3 STATUS (busy, pending, RO), 4 DETCNT (RO).
module pattern_cfg_apb (
  input  logic              clk,
  input  logic              rst,
  pattern_cfg_apb_if.slave  bus,
  output logic [4:0]        pat_out,
  output logic              ser_out,
  output logic              ser_valid,
  input  logic              det_in
);

  localparam logic [2:0] ADDR_CTRL    = 3'd0;
  localparam logic [2:0] ADDR_PATTERN = 3'd1;
  localparam logic [2:0] ADDR_TXDATA  = 3'd2;
  localparam logic [2:0] ADDR_STATUS  = 3'd3;
  localparam logic [2:0] ADDR_DETCNT  = 3'd4;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t     state_q;
  logic       en_q;
  logic [4:0] pattern_q;
  logic [7:0] detcnt_q;
  logic [7:0] shreg_q;
  logic [7:0] hold_q;
  logic [2:0] bitcnt_q;
  logic       pending_q;
  logic       valid_q;

  logic access;
  logic busy;
  logic err;
  logic wr_ok;
  logic tx_wr;
  logic last_bit;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign access   = bus.psel & bus.penable;
  assign busy     = (state_q == SHIFT);
  assign last_bit = (bitcnt_q == 3'd7);

  // A TXDATA write only errors when a word is already waiting; with en low
  // it is swallowed without an error.
  assign err = access & ((bus.paddr > ADDR_DETCNT) |
               (bus.pwrite & ((bus.paddr == ADDR_STATUS) | (bus.paddr == ADDR_DETCNT))) |
               (bus.pwrite & (bus.paddr == ADDR_TXDATA) & en_q & busy & pending_q));

  assign wr_ok = access & bus.pwrite & ~err;
  assign tx_wr = wr_ok & (bus.paddr == ADDR_TXDATA) & en_q;

  assign bus.pready  = access;
  assign bus.pslverr = err & rst;

  always_comb begin
    bus.prdata = 8'h00;
    if (access && !bus.pwrite && rst) begin
      case (bus.paddr)
        ADDR_CTRL:    bus.prdata = {7'b0, en_q};
        ADDR_PATTERN: bus.prdata = {3'b0, pattern_q};
        ADDR_STATUS:  bus.prdata = {6'b0, pending_q, busy};
        ADDR_DETCNT:  bus.prdata = detcnt_q;
        default:      bus.prdata = 8'h00;
      endcase
    end
  end

  assign pat_out   = pattern_q;
  assign ser_valid = valid_q;
  // The shift register keeps stale bits in IDLE, so qualify with valid.
  assign ser_out   = valid_q & shreg_q[7];

  // Configuration registers and detect counter; clear beats a same-edge detect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_q      <= 1'b0;
      pattern_q <= 5'd0;
      detcnt_q  <= 8'd0;
    end else begin
      if (wr_ok && bus.paddr == ADDR_CTRL)    en_q      <= bus.pwdata[0];
      if (wr_ok && bus.paddr == ADDR_PATTERN) pattern_q <= bus.pwdata[4:0];
      if (wr_ok && bus.paddr == ADDR_CTRL && bus.pwdata[1]) detcnt_q <= 8'd0;
      else if (det_in)                                      detcnt_q <= sat_inc(detcnt_q);
    end
  end

  // Holding register only carries data; pending_q says whether it is live.
  always_ff @(posedge clk) begin
    if (tx_wr && busy && !last_bit) hold_q <= bus.pwdata;
  end

  // Serializer FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      shreg_q   <= 8'd0;
      bitcnt_q  <= 3'd0;
      pending_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          valid_q <= 1'b0;
          if (tx_wr) begin
            shreg_q  <= bus.pwdata;
            bitcnt_q <= 3'd0;
            state_q  <= SHIFT;
            valid_q  <= 1'b1;
          end
        end
        SHIFT: begin
          if (!en_q) begin
            state_q   <= IDLE;
            valid_q   <= 1'b0;
            pending_q <= 1'b0;
            bitcnt_q  <= 3'd0;
          end else if (last_bit) begin
            bitcnt_q <= 3'd0;
            if (pending_q) begin
              shreg_q   <= hold_q;
              pending_q <= 1'b0;
            end else if (tx_wr) begin
              // A write landing on the final bit goes straight into the shifter.
              shreg_q <= bus.pwdata;
            end else begin
              state_q <= IDLE;
              valid_q <= 1'b0;
            end
          end else begin
            shreg_q  <= {shreg_q[6:0], 1'b0};
            bitcnt_q <= bitcnt_q + 3'd1;
            if (tx_wr) pending_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
